// File: rtl/cdb_arbiter_pkg.sv
// Shared widths and unit indices for the CDB arbiter, free-tag FIFO and RS.
package cdb_arbiter_pkg;

    localparam int unsigned TAG_WIDTH  = 6;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned N_REQ      = 4;
    localparam int unsigned IDX_WIDTH  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam int unsigned UNIT_ALU = 0;
    localparam int unsigned UNIT_MUL = 1;
    localparam int unsigned UNIT_DIV = 2;
    localparam int unsigned UNIT_LS  = 3;

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: double-width rotate, then lowest-set priority.
module cdb_arbiter_rr_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0]     req,
    input  logic [IDX_WIDTH-1:0] last_ptr,
    output logic [N_REQ-1:0]     grant_c,
    output logic [IDX_WIDTH-1:0] idx_c,
    output logic                 found_c
);

    logic [2*N_REQ-1:0] dbl;
    logic [2*N_REQ-1:0] rot;
    int                 start;
    int                 offset;
    int                 pos;

    // Rotate so the unit after last_ptr sits at bit 0, pick the first set bit, unrotate.
    always_comb begin
        dbl     = {req, req};
        start   = int'(last_ptr) + 1;
        if (start >= int'(N_REQ)) begin
            start = 0;
        end
        rot     = dbl >> start;
        found_c = 1'b0;
        offset  = 0;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found_c = 1'b1;
                offset  = k;
            end
        end
        pos = start + offset;
        if (pos >= int'(N_REQ)) begin
            pos = pos - int'(N_REQ);
        end
        grant_c = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            grant_c[i] = found_c && (pos == i);
        end
        idx_c = IDX_WIDTH'(pos);
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: round-robin picks one finished result per cycle and
// broadcasts it on registered CDB outputs one cycle after the grant.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*TAG_WIDTH-1:0]    req_tag,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]              req_grant,
    output logic                          cdb_valid,
    output logic [TAG_WIDTH-1:0]          cdb_tag,
    output logic [DATA_WIDTH-1:0]         cdb_data
);

    logic [IDX_WIDTH-1:0]  last_ptr;
    logic [N_REQ-1:0]      arb_grant;
    logic [IDX_WIDTH-1:0]  arb_idx;
    logic                  arb_found;
    logic                  granted;
    logic [TAG_WIDTH-1:0]  sel_tag;
    logic [DATA_WIDTH-1:0] sel_data;

    cdb_arbiter_rr_arbiter u_rr (
        .req      (req_valid),
        .last_ptr (last_ptr),
        .grant_c  (arb_grant),
        .idx_c    (arb_idx),
        .found_c  (arb_found)
    );

    // Flush and reset suppress the grant so nothing new enters the broadcast stage.
    always_comb begin
        req_grant = (flush || reset) ? '0 : arb_grant;
        granted   = arb_found && !flush && !reset;
    end

    // AND-OR payload mux keyed by the one-hot grant.
    always_comb begin
        sel_tag  = '0;
        sel_data = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            sel_tag  = sel_tag  | (req_tag[i*TAG_WIDTH +: TAG_WIDTH]     & {TAG_WIDTH{req_grant[i]}});
            sel_data = sel_data | (req_data[i*DATA_WIDTH +: DATA_WIDTH]  & {DATA_WIDTH{req_grant[i]}});
        end
    end

    // Priority pointer and CDB output registers; payload holds when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_ptr  <= IDX_WIDTH'(N_REQ - 1);
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
        end else begin
            cdb_valid <= granted;
            if (granted) begin
                last_ptr <= arb_idx;
                cdb_tag  <= sel_tag;
                cdb_data <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with a behavioural round-robin/CDB model.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        flush;
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*TAG_WIDTH-1:0]  req_tag;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            req_grant;
    logic                        cdb_valid;
    logic [TAG_WIDTH-1:0]        cdb_tag;
    logic [DATA_WIDTH-1:0]       cdb_data;

    cdb_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .req_grant (req_grant),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: who was served last and what the bus should show.
    int                    m_last;
    logic                  m_valid;
    logic [TAG_WIDTH-1:0]  m_tag;
    logic [DATA_WIDTH-1:0] m_data;
    int                    dut_log[$];
    int                    tag_seen[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_pick();
        for (int k = 1; k <= int'(N_REQ); k++) begin
            int u;
            u = (m_last + k) % int'(N_REQ);
            if (req_valid[u]) return u;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [N_REQ-1:0] g);
        int n;
        int r;
        n = 0;
        r = -1;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (g[i]) begin
                n++;
                r = i;
            end
        end
        return (n > 1) ? -2 : r;
    endfunction

    task automatic model_reset();
        m_last  = int'(N_REQ) - 1;
        m_valid = 1'b0;
        m_tag   = '0;
        m_data  = '0;
    endtask

    task automatic set_unit(input int i, input logic [TAG_WIDTH-1:0] t, input logic [DATA_WIDTH-1:0] d);
        req_tag[i*TAG_WIDTH +: TAG_WIDTH]    = t;
        req_data[i*DATA_WIDTH +: DATA_WIDTH] = d;
    endtask

    // One clock: compare at negedge, then advance the model across the posedge.
    task automatic step();
        int                    p;
        logic [N_REQ-1:0]      eg;
        logic [TAG_WIDTH-1:0]  nt;
        logic [DATA_WIDTH-1:0] nd;
        @(negedge clk);
        p  = flush ? -1 : model_pick();
        eg = '0;
        for (int i = 0; i < int'(N_REQ); i++) eg[i] = (p == i);
        chk("grant", 64'(req_grant), 64'(eg));
        chk("cdb_valid", 64'(cdb_valid), 64'(m_valid));
        chk("cdb_tag", 64'(cdb_tag), 64'(m_tag));
        chk("cdb_data", 64'(cdb_data), 64'(m_data));
        dut_log.push_back(onehot_idx(req_grant));
        if (p >= 0) begin
            nt = req_tag[p*TAG_WIDTH +: TAG_WIDTH];
            nd = req_data[p*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            nt = m_tag;
            nd = m_data;
        end
        @(posedge clk);
        m_valid = (p >= 0);
        if (p >= 0) m_last = p;
        m_tag  = nt;
        m_data = nd;
        #1;
        if (cdb_valid) tag_seen.push_back(int'(cdb_tag));
    endtask

    // Reset with all units requesting: grant must stay 0 while reset is high.
    task automatic do_reset();
        reset     = 1'b1;
        flush     = 1'b0;
        req_valid = '1;
        model_reset();
        @(negedge clk);
        chk("rst_grant", 64'(req_grant), 64'd0);
        chk("rst_valid", 64'(cdb_valid), 64'd0);
        chk("rst_tag", 64'(cdb_tag), 64'd0);
        chk("rst_data", 64'(cdb_data), 64'd0);
        req_valid = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        dut_log.delete();
        tag_seen.delete();
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        req_tag   = '0;
        req_data  = '0;
        for (int i = 0; i < int'(N_REQ); i++) set_unit(i, TAG_WIDTH'(10 + i), DATA_WIDTH'(32'h1000 * (i + 1)));

        // Idle after reset.
        do_reset();
        repeat (3) step();

        // Single request from the ALU.
        set_unit(UNIT_ALU, 6'd5, 32'hDEADBEEF);
        req_valid = 4'b0001;
        step();
        req_valid = 4'b0000;
        chk("t2_grant_lit", 64'(dut_log[3]), 64'(UNIT_ALU));
        chk("t2_valid_lit", 64'(cdb_valid), 64'd1);
        chk("t2_tag_lit", 64'(cdb_tag), 64'd5);
        chk("t2_data_lit", 64'(cdb_data), 64'hDEADBEEF);

        // Async reset between edges clears the bus immediately.
        #2 reset = 1'b1;
        #1;
        chk("async_valid", 64'(cdb_valid), 64'd0);
        chk("async_tag", 64'(cdb_tag), 64'd0);
        do_reset();

        // All four continuously: strict rotation, no bubbles.
        for (int i = 0; i < int'(N_REQ); i++) set_unit(i, TAG_WIDTH'(20 + i), DATA_WIDTH'(32'hA0 + i));
        req_valid = 4'b1111;
        repeat (8) step();
        for (int i = 0; i < 8; i++) chk($sformatf("t3_order%0d", i), 64'(dut_log[i]), 64'(i % 4));
        chk("t3_valid_lit", 64'(cdb_valid), 64'd1);
        do_reset();

        // Unit 1 just served; 1010 must go to unit 3 next, then alternate.
        req_valid = 4'b0010;
        step();
        req_valid = 4'b1010;
        repeat (3) step();
        chk("t4_a", 64'(dut_log[1]), 64'(UNIT_LS));
        chk("t4_b", 64'(dut_log[2]), 64'(UNIT_MUL));
        chk("t4_c", 64'(dut_log[3]), 64'(UNIT_LS));
        do_reset();

        // Flush right after a unit-2 grant.
        set_unit(UNIT_DIV, 6'd33, 32'hCAFE0002);
        req_valid = 4'b0100;
        step();
        req_valid = 4'b1111;
        flush     = 1'b1;
        step();
        flush = 1'b0;
        chk("t5_flush_grant", 64'(dut_log[1]), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t5_valid_after", 64'(cdb_valid), 64'd0);
        chk("t5_tag_held", 64'(cdb_tag), 64'd33);
        step();
        chk("t5_ptr_held", 64'(dut_log[2]), 64'(UNIT_LS));
        req_valid = 4'b0000;
        step();
        do_reset();

        // Tag return order on the broadcast stream.
        req_valid = 4'b0001;
        set_unit(UNIT_ALU, 6'd7, 32'h7);
        step();
        set_unit(UNIT_ALU, 6'd9, 32'h9);
        step();
        req_valid = 4'b0000;
        step();
        chk("t6_count", 64'(tag_seen.size()), 64'd2);
        if (tag_seen.size() == 2) begin
            chk("t6_first", 64'(tag_seen[0]), 64'd7);
            chk("t6_second", 64'(tag_seen[1]), 64'd9);
        end

        // Mixed patterns against the model, including mid-stream flushes.
        begin
            logic [N_REQ-1:0] pat [12];
            logic             fl  [12];
            pat = '{4'b1001, 4'b0110, 4'b1111, 4'b0000, 4'b1000, 4'b0011,
                    4'b1111, 4'b0101, 4'b1010, 4'b0111, 4'b1110, 4'b0001};
            fl  = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
            for (int i = 0; i < 12; i++) begin
                req_valid = pat[i];
                flush     = fl[i];
                step();
            end
            flush     = 1'b0;
            req_valid = '0;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
